// File: rtl/cgra_cfg_loader.sv
// Streams NF config frames onto cfg_data with one-hot strobes, optional clear first; accept-to-strobe T_SETUP+1 cycles.
// s_ready_o only in WAIT, so the source is stalled for the whole setup/strobe/hold window of each frame.
module cgra_cfg_loader #(
    parameter int FW      = 32,
    parameter int NF      = 2,
    parameter int T_SETUP = 1,
    parameter int T_STRB  = 1,
    parameter int T_HOLD  = 1,
    parameter int T_CLR   = 2,
    parameter int IW      = $clog2(NF + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic          abort_i,
    input  logic [FW-1:0] s_data_i,
    input  logic          s_valid_i,
    output logic          s_ready_o,
    output logic [FW-1:0] cfg_data_o,
    output logic [NF-1:0] cfg_strb_o,
    output logic          cfg_clr_o,
    output logic          busy_o,
    output logic          done_o,
    output logic [IW-1:0] frame_idx_o
);

    localparam int TM01 = (T_SETUP > T_STRB) ? T_SETUP : T_STRB;
    localparam int TM23 = (T_HOLD > T_CLR) ? T_HOLD : T_CLR;
    localparam int TMAX = (TM01 > TM23) ? TM01 : TM23;
    localparam int CW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    // Counter holds remaining cycles minus one, so zero means "last cycle of this state".
    localparam logic [CW-1:0] LD_SETUP = CW'(T_SETUP - 1);
    localparam logic [CW-1:0] LD_STRB  = CW'(T_STRB - 1);
    localparam logic [CW-1:0] LD_HOLD  = CW'(T_HOLD - 1);
    localparam logic [CW-1:0] LD_CLR   = CW'((T_CLR > 0) ? T_CLR - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_WAIT, S_SETUP, S_STROBE, S_HOLD, S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [FW-1:0] data_q, data_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          last;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
        data_d  = data_q;
        idx_d   = idx_q;
        last    = (cnt_q == '0);
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    idx_d   = '0;
                    state_d = (T_CLR > 0) ? S_CLEAR : S_WAIT;
                end
            end
            S_CLEAR:  if (last) state_d = S_WAIT;
            S_WAIT: begin
                if (s_valid_i) begin
                    data_d  = s_data_i;
                    state_d = S_SETUP;
                end
            end
            S_SETUP:  if (last) state_d = S_STROBE;
            S_STROBE: if (last) state_d = S_HOLD;
            S_HOLD: begin
                if (last) begin
                    idx_d   = idx_q + IW'(1);
                    state_d = (idx_q == IW'(NF - 1)) ? S_DONE : S_WAIT;
                end
            end
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        // Abort beats a same-cycle word accept or frame advance.
        if (abort_i && state_q != S_IDLE) begin
            state_d = S_IDLE;
            data_d  = data_q;
            idx_d   = idx_q;
        end
        if (state_d != state_q) begin
            case (state_d)
                S_CLEAR:  cnt_d = LD_CLR;
                S_SETUP:  cnt_d = LD_SETUP;
                S_STROBE: cnt_d = LD_STRB;
                S_HOLD:   cnt_d = LD_HOLD;
                default:  cnt_d = '0;
            endcase
        end
    end

    always_comb begin
        s_ready_o   = (state_q == S_WAIT);
        cfg_clr_o   = (state_q == S_CLEAR);
        busy_o      = (state_q != S_IDLE);
        done_o      = (state_q == S_DONE);
        cfg_data_o  = data_q;
        frame_idx_o = idx_q;
        cfg_strb_o  = '0;
        for (int i = 0; i < NF; i++) begin
            cfg_strb_o[i] = (state_q == S_STROBE) && (idx_q == IW'(i));
        end
    end

endmodule

// File: tb/tb_cgra_cfg_loader.sv
// Bench for cgra_cfg_loader: three parameterisations muxed onto one stimulus/observe port set,
// checked cycle by cycle against a timeline model built from the load-sequence timing rules.
module tb_cgra_cfg_loader;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, abort, s_valid;
    logic [31:0] s_data;
    int          sel;
    int          n_vec, n_err;

    logic        a_rdy, a_clr, a_busy, a_done, b_rdy, b_clr, b_busy, b_done, c_rdy, c_clr, c_busy, c_done;
    logic [31:0] a_data, b_data, c_data;
    logic [1:0]  a_strb, b_strb, a_idx, b_idx;
    logic [3:0]  c_strb;
    logic [2:0]  c_idx;

    cgra_cfg_loader #(.FW(32), .NF(2), .T_SETUP(1), .T_STRB(1), .T_HOLD(1), .T_CLR(2)) u_a (
        .clk_i(clk), .rst_i(rst), .start_i(start && sel == 0), .abort_i(abort && sel == 0),
        .s_data_i(s_data), .s_valid_i(s_valid && sel == 0), .s_ready_o(a_rdy),
        .cfg_data_o(a_data), .cfg_strb_o(a_strb), .cfg_clr_o(a_clr), .busy_o(a_busy),
        .done_o(a_done), .frame_idx_o(a_idx));

    cgra_cfg_loader #(.FW(32), .NF(2), .T_SETUP(3), .T_STRB(2), .T_HOLD(4), .T_CLR(0)) u_b (
        .clk_i(clk), .rst_i(rst), .start_i(start && sel == 1), .abort_i(abort && sel == 1),
        .s_data_i(s_data), .s_valid_i(s_valid && sel == 1), .s_ready_o(b_rdy),
        .cfg_data_o(b_data), .cfg_strb_o(b_strb), .cfg_clr_o(b_clr), .busy_o(b_busy),
        .done_o(b_done), .frame_idx_o(b_idx));

    cgra_cfg_loader #(.FW(32), .NF(4), .T_SETUP(2), .T_STRB(1), .T_HOLD(2), .T_CLR(1)) u_c (
        .clk_i(clk), .rst_i(rst), .start_i(start && sel == 2), .abort_i(abort && sel == 2),
        .s_data_i(s_data), .s_valid_i(s_valid && sel == 2), .s_ready_o(c_rdy),
        .cfg_data_o(c_data), .cfg_strb_o(c_strb), .cfg_clr_o(c_clr), .busy_o(c_busy),
        .done_o(c_done), .frame_idx_o(c_idx));

    logic        obs_rdy, obs_clr, obs_busy, obs_done;
    logic [3:0]  obs_strb;
    logic [2:0]  obs_idx;
    logic [31:0] obs_data;

    always_comb begin
        case (sel)
            1: begin
                {obs_rdy, obs_clr, obs_busy, obs_done} = {b_rdy, b_clr, b_busy, b_done};
                obs_strb = {2'b00, b_strb}; obs_idx = {1'b0, b_idx}; obs_data = b_data;
            end
            2: begin
                {obs_rdy, obs_clr, obs_busy, obs_done} = {c_rdy, c_clr, c_busy, c_done};
                obs_strb = c_strb; obs_idx = c_idx; obs_data = c_data;
            end
            default: begin
                {obs_rdy, obs_clr, obs_busy, obs_done} = {a_rdy, a_clr, a_busy, a_done};
                obs_strb = {2'b00, a_strb}; obs_idx = {1'b0, a_idx}; obs_data = a_data;
            end
        endcase
    end

    // Stimulus pattern, expected timeline, and recorded observations, indexed by cycle from start.
    bit          vld_pat [512];
    logic [31:0] words   [4];
    logic [31:0] d_dat   [512];
    logic        e_rdy [512], e_clr [512], e_busy [512], e_done [512];
    logic [3:0]  e_strb [512];
    int          e_idx  [512];
    logic [31:0] e_data [512];
    logic        o_rdy [512], o_clr [512], o_done [512];
    logic [3:0]  o_strb [512];
    logic [31:0] o_data [512];
    logic [31:0] last_data [3];
    int          last_idx  [3];

    task automatic get_cfg(input int s, output int nf, output int ts, output int tst,
                           output int th, output int tc);
        case (s)
            1:       begin nf = 2; ts = 3; tst = 2; th = 4; tc = 0; end
            2:       begin nf = 4; ts = 2; tst = 1; th = 2; tc = 1; end
            default: begin nf = 2; ts = 1; tst = 1; th = 1; tc = 2; end
        endcase
    endtask

    // Timeline model: each frame waits for the first valid cycle at or after ready, then runs
    // 1+setup+strobe+hold cycles; clear occupies cycles 1..T_CLR after a start in cycle 0.
    task automatic build_model(input int s, output int tdone);
        int nf, ts, tst, th, tc, t, a, prev;
        get_cfg(s, nf, ts, tst, th, tc);
        for (int c = 0; c < 512; c++) begin
            e_rdy[c] = 0; e_clr[c] = 0; e_busy[c] = 0; e_done[c] = 0; e_strb[c] = '0;
            e_idx[c] = (c == 0) ? last_idx[s] : 0;
            e_data[c] = last_data[s];
            d_dat[c] = $urandom;
        end
        for (int c = 1; c <= tc; c++) e_clr[c] = 1;
        t = 1 + tc;
        prev = 0;
        for (int k = 0; k < nf; k++) begin
            a = t;
            while (a < 480 && !vld_pat[a]) a++;
            for (int c = t; c <= a; c++) e_rdy[c] = 1;
            for (int c = prev + 1; c <= a; c++) d_dat[c] = words[k];
            for (int c = a + 1; c < 512; c++) e_data[c] = words[k];
            for (int c = a + 1 + ts; c <= a + ts + tst; c++) e_strb[c] = 4'(1) << k;
            t = a + 1 + ts + tst + th;
            for (int c = t; c < 512; c++) e_idx[c] = k + 1;
            prev = a;
        end
        e_done[t] = 1;
        for (int c = 1; c <= t; c++) e_busy[c] = 1;
        tdone = t;
    endtask

    task automatic test_sequence(input int s, input bit hold_start, output int tdone);
        int nf, ts, tst, th, tc;
        logic [42:0] exp_v, got_v;
        get_cfg(s, nf, ts, tst, th, tc);
        sel = s;
        build_model(s, tdone);
        for (int c = 0; c <= tdone + 2; c++) begin
            start   = (c == 0) || (hold_start && c <= tdone);
            abort   = 1'b0;
            s_valid = vld_pat[c];
            s_data  = d_dat[c];
            @(negedge clk);
            o_rdy[c] = obs_rdy; o_clr[c] = obs_clr; o_done[c] = obs_done;
            o_strb[c] = obs_strb; o_data[c] = obs_data;
            exp_v = {e_rdy[c], e_clr[c], e_busy[c], e_done[c], e_strb[c], 3'(e_idx[c]), e_data[c]};
            got_v = {obs_rdy, obs_clr, obs_busy, obs_done, obs_strb, obs_idx, obs_data};
            n_vec++;
            if (got_v !== exp_v) begin
                n_err++;
                $display("FAIL seq dut%0d cyc %0d {rdy,clr,busy,done,strb,idx,data} got %h want %h",
                         s, c, got_v, exp_v);
            end
            @(posedge clk); #1;
        end
        start = 1'b0; s_valid = 1'b0;
        last_data[s] = words[nf - 1];
        last_idx[s]  = nf;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; abort = 1'b1; s_valid = 1'b1; s_data = 32'hFFFF_FFFF;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = s; #1;
            n_vec++;
            if ({obs_rdy, obs_clr, obs_busy, obs_done, obs_strb, obs_idx, obs_data} !== 43'd0) begin
                n_err++;
                $display("FAIL reset dut%0d got %h want 0", s,
                         {obs_rdy, obs_clr, obs_busy, obs_done, obs_strb, obs_idx, obs_data});
            end
        end
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0; abort = 1'b0; s_valid = 1'b0; sel = 0;
        for (int s = 0; s < 3; s++) begin last_data[s] = '0; last_idx[s] = 0; end
    endtask

    task automatic test_basic();
        int td;
        words[0] = 32'h0000_00A5; words[1] = 32'hDEAD_BEEF;
        for (int c = 0; c < 512; c++) vld_pat[c] = 1'b1;
        test_sequence(0, 1'b0, td);
        n_vec += 9;
        if (o_clr[1] !== 1'b1 || o_clr[2] !== 1'b1 || o_clr[3] !== 1'b0) begin
            n_err++; $display("FAIL basic_clr got %b%b%b want 110", o_clr[1], o_clr[2], o_clr[3]);
        end
        if (o_rdy[3] !== 1'b1) begin n_err++; $display("FAIL basic_rdy3 got %b want 1", o_rdy[3]); end
        if (o_data[4] !== 32'hA5) begin n_err++; $display("FAIL basic_data4 got %h want a5", o_data[4]); end
        if (o_strb[5] !== 4'b0001) begin n_err++; $display("FAIL basic_strb5 got %b want 0001", o_strb[5]); end
        if (o_rdy[7] !== 1'b1) begin n_err++; $display("FAIL basic_rdy7 got %b want 1", o_rdy[7]); end
        if (o_strb[9] !== 4'b0010) begin n_err++; $display("FAIL basic_strb9 got %b want 0010", o_strb[9]); end
        if (o_done[11] !== 1'b1) begin n_err++; $display("FAIL basic_done11 got %b want 1", o_done[11]); end
        if (o_data[12] !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL basic_data_kept got %h want deadbeef", o_data[12]); end
        if (o_strb[8] !== 4'b0000) begin n_err++; $display("FAIL basic_strb8 got %b want 0000", o_strb[8]); end
    endtask

    task automatic test_stall();
        int td, nd;
        words[0] = $urandom; words[1] = $urandom;
        for (int c = 0; c < 512; c++) vld_pat[c] = !(c >= 7 && c <= 16);
        test_sequence(0, 1'b0, td);
        for (int c = 7; c <= 16; c++) begin
            n_vec++;
            if (o_rdy[c] !== 1'b1 || o_strb[c] !== 4'b0) begin
                n_err++; $display("FAIL stall_wait cyc %0d rdy %b strb %b want 1 0000", c, o_rdy[c], o_strb[c]);
            end
        end
        nd = 0;
        for (int c = 0; c <= td + 2; c++) nd += int'(o_done[c]);
        n_vec += 3;
        if (o_strb[19] !== 4'b0010) begin n_err++; $display("FAIL stall_strb19 got %b want 0010", o_strb[19]); end
        if (o_done[21] !== 1'b1) begin n_err++; $display("FAIL stall_done21 got %b want 1", o_done[21]); end
        if (nd != 1) begin n_err++; $display("FAIL stall_done_count got %0d want 1", nd); end
    endtask

    task automatic test_timing();
        int td;
        words[0] = $urandom; words[1] = $urandom;
        for (int c = 0; c < 512; c++) vld_pat[c] = 1'b1;
        test_sequence(1, 1'b0, td);
        n_vec += 7;
        if (o_strb[4] !== 4'b0) begin n_err++; $display("FAIL timing_strb4 got %b want 0000", o_strb[4]); end
        if (o_strb[5] !== 4'b0001 || o_strb[6] !== 4'b0001) begin
            n_err++; $display("FAIL timing_strb_hi got %b %b want 0001 0001", o_strb[5], o_strb[6]);
        end
        if (o_strb[7] !== 4'b0) begin n_err++; $display("FAIL timing_strb7 got %b want 0000", o_strb[7]); end
        if (o_rdy[10] !== 1'b0) begin n_err++; $display("FAIL timing_rdy10 got %b want 0", o_rdy[10]); end
        if (o_rdy[11] !== 1'b1) begin n_err++; $display("FAIL timing_rdy11 got %b want 1", o_rdy[11]); end
        if (o_rdy[1] !== 1'b1) begin n_err++; $display("FAIL timing_rdy1 got %b want 1", o_rdy[1]); end
        if (o_clr.or() !== 1'b0) begin n_err++; $display("FAIL timing_noclr got %b want 0", o_clr.or()); end
    endtask

    task automatic test_abort();
        int td;
        logic [42:0] got_v;
        words[0] = $urandom; words[1] = $urandom;
        sel = 0;
        for (int c = 0; c <= 5; c++) begin
            start = (c == 0); s_valid = 1'b1; s_data = words[0]; abort = (c == 5);
            @(negedge clk);
            if (c == 5) begin
                n_vec++;
                if (obs_strb !== 4'b0001) begin n_err++; $display("FAIL abort_in_strobe got %b want 0001", obs_strb); end
            end
            @(posedge clk); #1;
        end
        abort = 1'b0; start = 1'b0; s_valid = 1'b0;
        @(negedge clk);
        got_v = {obs_rdy, obs_clr, obs_busy, obs_done, obs_strb, obs_idx, obs_data};
        n_vec++;
        if (got_v !== {11'd0, words[0]}) begin
            n_err++; $display("FAIL abort_after got %h want %h", got_v, {11'd0, words[0]});
        end
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); @(negedge clk);
            n_vec++;
            if ({obs_busy, obs_done} !== 2'b00) begin n_err++; $display("FAIL abort_idle busy/done %b%b want 00", obs_busy, obs_done); end
        end
        @(posedge clk); #1;
        last_data[0] = words[0]; last_idx[0] = 0;
        words[0] = $urandom; words[1] = $urandom;
        for (int c = 0; c < 512; c++) vld_pat[c] = 1'b1;
        test_sequence(0, 1'b0, td);
        // Abort against a valid word in WAIT must leave the bus untouched.
        for (int c = 0; c <= 3; c++) begin
            start = (c == 0); s_valid = (c == 3); s_data = 32'h1234_5678; abort = (c == 3);
            @(negedge clk);
            if (c == 3) begin
                n_vec++;
                if (obs_rdy !== 1'b1) begin n_err++; $display("FAIL abort_wait_rdy got %b want 1", obs_rdy); end
            end
            @(posedge clk); #1;
        end
        abort = 1'b0; start = 1'b0; s_valid = 1'b0;
        @(negedge clk);
        got_v = {obs_rdy, obs_clr, obs_busy, obs_done, obs_strb, obs_idx, obs_data};
        n_vec++;
        if (got_v !== {11'd0, last_data[0]}) begin
            n_err++; $display("FAIL abort_wait_noaccept got %h want %h", got_v, {11'd0, last_data[0]});
        end
        @(posedge clk); #1;
        last_idx[0] = 0;
    endtask

    task automatic test_reset_mid();
        int td;
        logic [42:0] got_v;
        words[0] = $urandom; words[1] = $urandom;
        sel = 0;
        for (int c = 0; c <= 6; c++) begin
            start = 1'b1; s_valid = 1'b1; s_data = words[0]; rst = (c == 6);
            @(negedge clk);
            if (c == 6) begin
                n_vec++;
                if ({obs_busy, obs_strb, obs_data} !== {1'b1, 4'b0, words[0]}) begin
                    n_err++; $display("FAIL rst_in_hold got %h want %h", {obs_busy, obs_strb, obs_data}, {1'b1, 4'b0, words[0]});
                end
            end
            @(posedge clk); #1;
        end
        rst = 1'b0; start = 1'b0; s_valid = 1'b0;
        @(negedge clk);
        got_v = {obs_rdy, obs_clr, obs_busy, obs_done, obs_strb, obs_idx, obs_data};
        n_vec++;
        if (got_v !== 43'd0) begin n_err++; $display("FAIL rst_mid got %h want 0", got_v); end
        @(posedge clk); #1;
        for (int s = 0; s < 3; s++) begin last_data[s] = '0; last_idx[s] = 0; end
        words[0] = $urandom; words[1] = $urandom;
        for (int c = 0; c < 512; c++) vld_pat[c] = 1'b1;
        test_sequence(0, 1'b1, td);
    endtask

    task automatic test_random();
        int td;
        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < 4; k++) words[k] = $urandom;
            for (int c = 0; c < 512; c++) vld_pat[c] = (c >= 300) || ($urandom_range(0, 2) != 0);
            test_sequence((r % 3), 1'b0, td);
        end
    endtask

    task automatic test_chain();
        int td;
        logic [31:0] tile [4];
        for (int k = 0; k < 4; k++) begin words[k] = $urandom; tile[k] = 'x; end
        for (int c = 0; c < 512; c++) vld_pat[c] = (c >= 300) || ($urandom_range(0, 1) != 0);
        test_sequence(2, 1'b0, td);
        for (int c = 1; c <= td + 2; c++) begin
            for (int b = 0; b < 4; b++) if (o_strb[c][b]) tile[b] = o_data[c];
            if (o_strb[c] != 4'b0) begin
                n_vec++;
                if (o_data[c] !== o_data[c - 1]) begin
                    n_err++; $display("FAIL chain_stable cyc %0d data %h prev %h", c, o_data[c], o_data[c - 1]);
                end
            end
        end
        for (int b = 0; b < 4; b++) begin
            n_vec++;
            if (tile[b] !== words[b]) begin
                n_err++; $display("FAIL chain_tile%0d got %h want %h", b, tile[b], words[b]);
            end
        end
    endtask

    initial begin
        n_vec = 0; n_err = 0; sel = 0;
        rst = 1'b0; start = 1'b0; abort = 1'b0; s_valid = 1'b0; s_data = '0;
        #1;
        test_reset();
        test_basic();
        test_stall();
        test_timing();
        test_abort();
        test_reset_mid();
        test_random();
        test_chain();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
